sobel_mem_host: RTL and testbench

SOBEL_MEM_HOST -- requirements
Module: sobel_mem_host

---
 rtl/sobel_mem_host.sv | 220 ++++++++++++++++++++++
 tb/tb_sobel_mem_host.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_mem_host.sv
// Host wrapper for an ap_ctrl_hs Sobel core: loads a frame into the input RAM, runs
// the core, serves its RAM/ROM ports, then streams the output RAM back out.
module sobel_mem_host #(
  parameter int DEPTH = 262144,
  parameter int AW    = 18
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          busy,
  output logic          ap_start,
  input  logic          ap_done,
  input  logic          ap_idle,
  input  logic          ap_ready,
  input  logic [AW-1:0] indata_address0,
  input  logic          indata_ce0,
  output logic [7:0]    indata_q0,
  input  logic [AW-1:0] GX_address0,
  input  logic          GX_ce0,
  output logic [31:0]   GX_q0,
  input  logic [AW-1:0] GY_address0,
  input  logic          GY_ce0,
  output logic [31:0]   GY_q0,
  input  logic [AW-1:0] outdata_address0,
  input  logic          outdata_ce0,
  input  logic          outdata_we0,
  input  logic [7:0]    outdata_d0
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1'b1);
  localparam logic [AW:0] LAST_L  = DEPTH_L - ONE_L;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  state_t      state_r;
  logic [AW:0] load_cnt_r;
  logic [AW:0] unl_cnt_r;
  logic [AW:0] unl_next_s;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [7:0]  out_data_r;
  logic        busy_r;
  logic        ap_start_r;
  logic [7:0]  indata_q0_r;
  logic [31:0] gx_q0_r;
  logic [31:0] gy_q0_r;
  logic        load_we_s;
  logic [IW-1:0] load_addr_s;
  logic        unused_ap_idle_s;

  logic [7:0] in_mem_r  [0:DEPTH-1];
  logic [7:0] out_mem_r [0:DEPTH-1];

  function automatic logic [31:0] gx_coef(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd6: gx_coef = 32'hFFFF_FFFF;
      4'd3:       gx_coef = 32'hFFFF_FFFE;
      4'd2, 4'd8: gx_coef = 32'h0000_0001;
      4'd5:       gx_coef = 32'h0000_0002;
      default:    gx_coef = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] gy_coef(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd2: gy_coef = 32'hFFFF_FFFF;
      4'd1:       gy_coef = 32'hFFFF_FFFE;
      4'd6, 4'd8: gy_coef = 32'h0000_0001;
      4'd7:       gy_coef = 32'h0000_0002;
      default:    gy_coef = 32'h0000_0000;
    endcase
  endfunction

  assign unused_ap_idle_s = ap_idle;

  // Input RAM write strobe: the first beat of a frame always lands at address 0
  always_comb begin
    load_we_s   = 1'b0;
    load_addr_s = {IW{1'b0}};
    if (in_valid && in_ready_r && (state_r == S_IDLE || state_r == S_LOAD)) begin
      load_we_s   = 1'b1;
      load_addr_s = (state_r == S_IDLE) ? {IW{1'b0}} : load_cnt_r[IW-1:0];
    end else begin
      load_we_s   = 1'b0;
    end
  end

  assign unl_next_s = unl_cnt_r + ONE_L;

  // RAM arrays carry no reset so frame data survives reset and state changes
  always_ff @(posedge ap_clk) begin
    if (load_we_s) in_mem_r[load_addr_s] <= in_data;
    if (outdata_ce0 && outdata_we0 && ({1'b0, outdata_address0} < DEPTH_L))
      out_mem_r[outdata_address0[IW-1:0]] <= outdata_d0;
  end

  // Core-side read ports: one-cycle latency, hold while ce0 is low, zero when out of range
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      indata_q0_r <= 8'd0;
      gx_q0_r     <= 32'd0;
      gy_q0_r     <= 32'd0;
    end else begin
      if (indata_ce0)
        indata_q0_r <= ({1'b0, indata_address0} < DEPTH_L) ? in_mem_r[indata_address0[IW-1:0]] : 8'd0;
      if (GX_ce0)
        gx_q0_r <= (GX_address0 < AW'(4'd9)) ? gx_coef(GX_address0[3:0]) : 32'd0;
      if (GY_ce0)
        gy_q0_r <= (GY_address0 < AW'(4'd9)) ? gy_coef(GY_address0[3:0]) : 32'd0;
    end
  end

  // Frame sequencing FSM with registered handshake outputs
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r     <= S_IDLE;
      load_cnt_r  <= {(AW+1){1'b0}};
      unl_cnt_r   <= {(AW+1){1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
      busy_r      <= 1'b0;
      ap_start_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          in_ready_r <= 1'b1;
          if (in_valid && in_ready_r) begin
            load_cnt_r <= ONE_L;
            busy_r     <= 1'b1;
            if (DEPTH == 1) begin
              state_r    <= S_START;
              in_ready_r <= 1'b0;
              ap_start_r <= 1'b1;
            end else begin
              state_r <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready_r) begin
            load_cnt_r <= load_cnt_r + ONE_L;
            if (load_cnt_r == LAST_L) begin
              state_r    <= S_START;
              in_ready_r <= 1'b0;
              ap_start_r <= 1'b1;
            end
          end
        end
        S_START: begin
          if (ap_done) begin
            state_r     <= S_UNLOAD;
            ap_start_r  <= 1'b0;
            unl_cnt_r   <= {(AW+1){1'b0}};
            out_valid_r <= 1'b0;
          end else if (ap_ready) begin
            state_r    <= S_RUN;
            ap_start_r <= 1'b0;
          end
        end
        S_RUN: begin
          if (ap_done) begin
            state_r     <= S_UNLOAD;
            unl_cnt_r   <= {(AW+1){1'b0}};
            out_valid_r <= 1'b0;
          end
        end
        S_UNLOAD: begin
          // Prefetch the next word on each accepted beat so the stream has no bubbles
          if (out_valid_r && out_ready) begin
            if (unl_cnt_r == LAST_L) begin
              state_r     <= S_IDLE;
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              in_ready_r  <= 1'b1;
              load_cnt_r  <= {(AW+1){1'b0}};
              unl_cnt_r   <= {(AW+1){1'b0}};
            end else begin
              unl_cnt_r  <= unl_next_s;
              out_data_r <= out_mem_r[unl_next_s[IW-1:0]];
            end
          end else if (!out_valid_r) begin
            out_data_r  <= out_mem_r[unl_cnt_r[IW-1:0]];
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          ap_start_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign ap_start  = ap_start_r;
  assign indata_q0 = indata_q0_r;
  assign GX_q0     = gx_q0_r;
  assign GY_q0     = gy_q0_r;

endmodule

// File: tb/tb_sobel_mem_host.sv
// Self-checking bench for sobel_mem_host at DEPTH=16: array-based frame model with
// randomized pixels, core writes and output back-pressure.
module tb_sobel_mem_host;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          in_valid, in_ready;
  logic [7:0]    in_data;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;
  logic          busy, ap_start, ap_done, ap_idle, ap_ready;
  logic [AW-1:0] indata_address0, GX_address0, GY_address0, outdata_address0;
  logic          indata_ce0, GX_ce0, GY_ce0, outdata_ce0, outdata_we0;
  logic [7:0]    indata_q0, outdata_d0;
  logic [31:0]   GX_q0, GY_q0;

  int err_cnt = 0;
  int chk_cnt = 0;
  int gx_tab[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int gy_tab[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
  logic [7:0] in_img  [DEPTH];
  logic [7:0] out_img [DEPTH];

  sobel_mem_host #(.DEPTH(DEPTH), .AW(AW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .indata_address0(indata_address0), .indata_ce0(indata_ce0), .indata_q0(indata_q0),
    .GX_address0(GX_address0), .GX_ce0(GX_ce0), .GX_q0(GX_q0),
    .GY_address0(GY_address0), .GY_ce0(GY_ce0), .GY_q0(GY_q0),
    .outdata_address0(outdata_address0), .outdata_ce0(outdata_ce0),
    .outdata_we0(outdata_we0), .outdata_d0(outdata_d0)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gx_ref(input int a);
    if (a < 9) return 32'(gx_tab[a]);
    else return 32'd0;
  endfunction

  function automatic logic [31:0] gy_ref(input int a);
    if (a < 9) return 32'(gy_tab[a]);
    else return 32'd0;
  endfunction

  task automatic load_frame(input bit seq);
    for (int k = 0; k < DEPTH; k++) begin
      in_img[k] = seq ? 8'(k) : 8'($urandom_range(0, 255));
      in_data   = in_img[k];
      in_valid  = 1'b1;
      for (int w = 0; w < 8 && !in_ready; w++) tick();
      chk("ld_ready", 32'(in_ready), 32'd1);
      tick();
    end
    chk("ld_end_ready", 32'(in_ready), 32'd0);
    chk("ld_end_start", 32'(ap_start), 32'd1);
    chk("ld_end_busy", 32'(busy), 32'd1);
    tick();
    chk("start_ready", 32'(in_ready), 32'd0);
    chk("start_start", 32'(ap_start), 32'd1);
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic run_handshake(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("start_held", 32'(ap_start), 32'd1);
    end
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    chk("start_drop", 32'(ap_start), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
  endtask

  task automatic core_rd(input int ia, input int gxa, input int gya);
    logic [7:0] exp_in;
    indata_address0 = AW'(ia);  GX_address0 = AW'(gxa);  GY_address0 = AW'(gya);
    indata_ce0 = 1'b1;  GX_ce0 = 1'b1;  GY_ce0 = 1'b1;
    tick();
    indata_ce0 = 1'b0;  GX_ce0 = 1'b0;  GY_ce0 = 1'b0;
    indata_address0 = AW'($urandom_range(0, 31));
    GX_address0     = AW'($urandom_range(0, 31));
    GY_address0     = AW'($urandom_range(0, 31));
    exp_in = (ia < DEPTH) ? in_img[ia] : 8'd0;
    chk("rd_in", 32'(indata_q0), 32'(exp_in));
    chk("rd_gx", GX_q0, gx_ref(gxa));
    chk("rd_gy", GY_q0, gy_ref(gya));
    tick();
    chk("hold_in", 32'(indata_q0), 32'(exp_in));
    chk("hold_gx", GX_q0, gx_ref(gxa));
    chk("hold_gy", GY_q0, gy_ref(gya));
  endtask

  task automatic core_wr(input int a, input logic [7:0] d, input logic ce, input logic we);
    outdata_address0 = AW'(a);
    outdata_d0  = d;
    outdata_ce0 = ce;
    outdata_we0 = we;
    tick();
    outdata_ce0 = 1'b0;
    outdata_we0 = 1'b0;
    if (ce && we && a < DEPTH) out_img[a] = d;
  endtask

  task automatic unload(input int stop, input bit pat);
    int  got   = 0;
    int  first = -1;
    bit  hs;
    for (int c = 0; c < 300 && got < stop; c++) begin
      out_ready = pat ? ((c % 4) == 0 || (c % 4) == 3) : 1'($urandom_range(0, 1));
      if (first >= 0) chk("no_gap", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (first < 0) begin
          first = c;
          chk("first_lat", 32'(c <= 2), 32'd1);
        end
        chk("out_data", 32'(out_data), 32'(out_img[got]));
      end
      hs = out_valid && out_ready;
      tick();
      if (hs) got++;
    end
    chk("beat_cnt", 32'(got), 32'(stop));
    out_ready = 1'b0;
  endtask

  task automatic frame_end_chk();
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_ready", 32'(in_ready), 32'd1);
    tick();
    chk("end_no_extra", 32'(out_valid), 32'd0);
  endtask

  initial begin
    ap_rst = 1'b1;
    in_valid = 1'b0;  in_data = 8'd0;  out_ready = 1'b0;
    ap_done = 1'b0;  ap_idle = 1'b0;  ap_ready = 1'b0;
    indata_address0 = 5'd0;  GX_address0 = 5'd3;  GY_address0 = 5'd1;
    indata_ce0 = 1'b0;  GX_ce0 = 1'b1;  GY_ce0 = 1'b1;
    outdata_address0 = 5'd0;  outdata_ce0 = 1'b0;  outdata_we0 = 1'b0;  outdata_d0 = 8'd0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(ap_start), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_indata_q", 32'(indata_q0), 32'd0);
    chk("rst_gx_q", GX_q0, 32'd0);
    chk("rst_gy_q", GY_q0, 32'd0);
    GX_ce0 = 1'b0;  GY_ce0 = 1'b0;
    ap_rst = 1'b0;

    // Frame 1: ramp pixels, fixed back-pressure pattern
    load_frame(1'b1);
    run_handshake(5);
    core_rd(5, 3, 9);
    core_rd(20, 8, 0);
    repeat (4) core_rd($urandom_range(0, 15), $urandom_range(0, 12), $urandom_range(0, 12));
    for (int a = 0; a < DEPTH; a++) core_wr(a, 8'hA0 + 8'(a), 1'b1, 1'b1);
    core_wr(16, 8'h55, 1'b1, 1'b1);
    core_wr(3, 8'h33, 1'b1, 1'b0);
    core_wr(4, 8'h44, 1'b0, 1'b1);
    chk("run_no_out", 32'(out_valid), 32'd0);
    chk("run_busy2", 32'(busy), 32'd1);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    unload(DEPTH, 1'b1);
    frame_end_chk();
    ap_done = 1'b1;
    ap_ready = 1'b1;
    tick();
    ap_done = 1'b0;
    ap_ready = 1'b0;
    tick();
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_start", 32'(ap_start), 32'd0);
    chk("idle_done_valid", 32'(out_valid), 32'd0);
    chk("idle_done_ready", 32'(in_ready), 32'd1);

    // Frame 2: random data, aborted by reset after 8 output beats
    load_frame(1'b0);
    run_handshake($urandom_range(0, 3));
    for (int a = 0; a < DEPTH; a++) core_wr(a, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    unload(8, 1'b0);
    ap_rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_data", 32'(out_data), 32'd0);
    chk("abort_q", 32'(indata_q0), 32'd0);
    repeat (2) tick();
    ap_rst = 1'b0;

    // Frame 3: new load from pixel 0, partial rewrite, ap_done straight from START
    load_frame(1'b0);
    for (int k = 0; k < DEPTH; k++) core_rd(k, $urandom_range(0, 12), $urandom_range(0, 12));
    for (int a = 0; a < DEPTH; a += 2) core_wr(a, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
    chk("f3_start", 32'(ap_start), 32'd1);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    chk("f3_start_drop", 32'(ap_start), 32'd0);
    unload(DEPTH, 1'b0);
    frame_end_chk();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
